frame_sprite_updater: RTL

Consumer of the game engine's per-frame advance pulse (game_scen). Each accepted tick runs a fixed multi-cycle update sequence:
- sample the direction buttons
- compute the new clamped sprite X, then Y
- commit the new position and pulse frame_done for the renderer and collision logic.

It also counts frames and counts ticks dropped because an update was still in progress.

---
 rtl/frame_sprite_updater.sv | 110 +++++++++++
 1 files changed

// File: rtl/frame_sprite_updater.sv
// Frame-driven sprite mover: each accepted game_scen tick samples the buttons,
// steps and clamps X then Y, and commits the new position with a frame_done pulse.
module frame_sprite_updater #(
  parameter int COORD_W = 10,
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int SPR_W   = 16,
  parameter int SPR_H   = 16,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int SPEED   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_scen,
  input  logic               pause,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [COORD_W-1:0] sprite_x,
  output logic [COORD_W-1:0] sprite_y,
  output logic [15:0]        frame_count,
  output logic [7:0]         overrun_count,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic [2:0] {IDLE, SAMPLE, MOVE_X, MOVE_Y, COMMIT} state_e;

  localparam logic [COORD_W:0] SPEED_W = (COORD_W+1)'(SPEED);
  localparam logic [COORD_W:0] X_LIM   = (COORD_W+1)'(X_MAX - SPR_W + 1);
  localparam logic [COORD_W:0] Y_LIM   = (COORD_W+1)'(Y_MAX - SPR_H + 1);

  state_e             state_q;
  logic [3:0]         btn_q;  // {left, right, up, down} as seen in SAMPLE
  logic [COORD_W-1:0] work_x_q, work_x_d, move_y_d;
  logic [COORD_W-1:0] sprite_x_q, sprite_y_q;
  logic [15:0]        frame_count_q;
  logic [7:0]         overrun_count_q;

  // One axis step; the sum is one bit wider so the upper clamp cannot wrap.
  function automatic logic [COORD_W-1:0] step_axis(
    input logic [COORD_W-1:0] pos,
    input logic               dec,
    input logic               inc,
    input logic [COORD_W:0]   lim
  );
    logic [COORD_W:0] wide;
    logic [COORD_W:0] sum;
    wide      = {1'b0, pos};
    sum       = wide + SPEED_W;
    step_axis = pos;
    if (dec && !inc)
      step_axis = (wide < SPEED_W) ? '0 : pos - SPEED_W[COORD_W-1:0];
    else if (inc && !dec)
      step_axis = (sum > lim) ? lim[COORD_W-1:0] : sum[COORD_W-1:0];
  endfunction

  always_comb begin
    work_x_d = step_axis(sprite_x_q, btn_q[3], btn_q[2], X_LIM);
    move_y_d = step_axis(sprite_y_q, btn_q[1], btn_q[0], Y_LIM);
  end

  // NOTE: non-blocking assignments keep every register reading pre-edge values,
  // so ordering of statements inside this block never changes behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      btn_q           <= '0;
      work_x_q        <= (COORD_W)'(X_INIT);
      sprite_x_q      <= (COORD_W)'(X_INIT);
      sprite_y_q      <= (COORD_W)'(Y_INIT);
      frame_count_q   <= '0;
      overrun_count_q <= '0;
    end else begin
      // Ticks arriving mid-update are dropped and counted, whatever pause says.
      if (game_scen && state_q != IDLE && overrun_count_q != 8'hFF)
        overrun_count_q <= overrun_count_q + 8'd1;

      case (state_q)
        IDLE:   if (game_scen && !pause) state_q <= SAMPLE;
        SAMPLE: begin
          btn_q   <= {btn_left, btn_right, btn_up, btn_down};
          state_q <= MOVE_X;
        end
        MOVE_X: begin
          work_x_q <= work_x_d;
          state_q  <= MOVE_Y;
        end
        MOVE_Y: begin
          sprite_x_q    <= work_x_q;
          sprite_y_q    <= move_y_d;
          frame_count_q <= frame_count_q + 16'd1;
          state_q       <= COMMIT;
        end
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sprite_x      = sprite_x_q;
  assign sprite_y      = sprite_y_q;
  assign frame_count   = frame_count_q;
  assign overrun_count = overrun_count_q;
  assign busy          = (state_q != IDLE);
  assign frame_done    = (state_q == COMMIT);

endmodule
